// File: rtl/param_counter.sv
// Modulo-N up/down counter with load, boundary pulse and sticky boundary flag.
// Define PARAM_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module param_counter #(
  parameter int unsigned     WIDTH   = 3,
  parameter longint unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             count_up,
  input  logic             count_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap,
  output logic             wrap_sticky
);

  // One extra bit so MODULUS == 2**WIDTH is representable in compares.
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  typedef struct packed {
    logic [WIDTH:0] cnt;
    logic           evt;
  } nxt_t;

  logic [WIDTH:0] cnt_x, ld_x;
  nxt_t           nxt;
  logic           unused_msb;

  assign cnt_x      = {1'b0, count};
  assign ld_x       = {1'b0, load_value};
  assign at_max     = (cnt_x == MAX_X);
  assign at_zero    = (count == '0);
  assign unused_msb = nxt.cnt[WIDTH];

  always_comb begin
    nxt.cnt = cnt_x;
    nxt.evt = 1'b0;
    if (load) begin
      nxt.cnt = (ld_x >= MOD_X) ? MAX_X : ld_x;
    end else if (en && (count_up ^ count_down)) begin
      if (count_up) begin
        if (cnt_x == MAX_X) begin
          nxt.evt = 1'b1;
`ifdef PARAM_COUNTER_SATURATE_EN
          nxt.cnt = MAX_X;
`else
          nxt.cnt = '0;
`endif
        end else begin
          nxt.cnt = cnt_x + ONE_X;
        end
      end else begin
        if (cnt_x == '0) begin
          nxt.evt = 1'b1;
`ifdef PARAM_COUNTER_SATURATE_EN
          nxt.cnt = '0;
`else
          nxt.cnt = MAX_X;
`endif
        end else begin
          nxt.cnt = cnt_x - ONE_X;
        end
      end
    end
  end

  // Set wins over clear on the sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      wrap        <= 1'b0;
      wrap_sticky <= 1'b0;
    end else begin
      count       <= nxt.cnt[WIDTH-1:0];
      wrap        <= nxt.evt;
      wrap_sticky <= nxt.evt | (wrap_sticky & ~clear_flag);
    end
  end

endmodule
